// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: widths, register indices, ExcCodes and Cause bit fields.
package cp0_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RIDX_W = 5;
   localparam int unsigned CODE_W = 5;

   // CP0 register indices (rd field of mfc0/mtc0)
   localparam logic [RIDX_W-1:0] CP0_COUNT   = 5'd9;
   localparam logic [RIDX_W-1:0] CP0_COMPARE = 5'd11;
   localparam logic [RIDX_W-1:0] CP0_STATUS  = 5'd12;
   localparam logic [RIDX_W-1:0] CP0_CAUSE   = 5'd13;
   localparam logic [RIDX_W-1:0] CP0_EPC     = 5'd14;

   // ExcCode values presented on cause
   localparam logic [CODE_W-1:0] EXC_SYSCALL = 5'd8;
   localparam logic [CODE_W-1:0] EXC_BREAK   = 5'd9;
   localparam logic [CODE_W-1:0] EXC_TEQ     = 5'd13;

   // Cause / Status bit positions
   localparam int unsigned CAUSE_IP7     = 15;
   localparam int unsigned CAUSE_EXC_LSB = 2;
   localparam int unsigned CAUSE_EXC_MSB = 6;
   localparam int unsigned CAUSE_SW_LSB  = 8;
   localparam int unsigned CAUSE_SW_MSB  = 9;
   localparam int unsigned STATUS_IE     = 0;
   localparam int unsigned STATUS_IM7    = 15;

endpackage

// File: rtl/cp0_if.sv
// CPU <-> CP0 bus. master = CPU controller side, slave = cp0_unit side.
//   mfc0/mtc0/rd/wdata : register access; pc/exception/eret/cause : exception control
//   rdata/status/exc_addr/timer_irq : results returned to the CPU
interface cp0_if;
   import cp0_pkg::*;

   logic              mfc0;
   logic              mtc0;
   logic [DATA_W-1:0] pc;
   logic [RIDX_W-1:0] rd;
   logic [DATA_W-1:0] wdata;
   logic              exception;
   logic              eret;
   logic [CODE_W-1:0] cause;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] exc_addr;
   logic              timer_irq;

   modport master (
      output mfc0, mtc0, pc, rd, wdata, exception, eret, cause,
      input  rdata, status, exc_addr, timer_irq
   );

   modport slave (
      input  mfc0, mtc0, pc, rd, wdata, exception, eret, cause,
      output rdata, status, exc_addr, timer_irq
   );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare pair. Count free-runs unless loaded; match_c flags that the
// next Count equals a nonzero Compare.
//   count_we/compare_we/wdata : load strobes and data
//   count/compare             : current register values
//   match_c                   : combinational match pulse for this edge
module cp0_timer
   import cp0_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              count_we,
   input  logic              compare_we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] count,
   output logic [DATA_W-1:0] compare,
   output logic              match_c
);

   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] compare_q, compare_d;

   // Next-state: a load replaces the increment; wrap is natural modulo 2^32
   always_comb begin
      count_d   = count_q + DATA_W'(1);
      compare_d = compare_q;
      if (count_we)   count_d   = wdata;
      if (compare_we) compare_d = wdata;
      match_c = (count_d == compare_q) && (compare_q != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC plus Count/Compare timer, exception entry
// and return bookkeeping, timer interrupt request.
//   clk, reset : clock and synchronous active-high reset
//   bus        : cp0_if slave port (access strobes in, rdata/status/exc_addr/timer_irq out)
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [DATA_W-1:0] EXC_VECTOR   = 32'h0040_0004,
   parameter logic [DATA_W-1:0] STATUS_RESET = 32'h0000_0001,
   parameter int unsigned       EXC_SHIFT    = 5
) (
   input  logic  clk,
   input  logic  reset,
   cp0_if.slave  bus
);

   logic [DATA_W-1:0] status_q, status_d;
   logic [DATA_W-1:0] cause_q, cause_d;
   logic [DATA_W-1:0] epc_q, epc_d;
   logic [DATA_W-1:0] count, compare;
   logic              match_c;
   logic              count_we, compare_we;
   logic [DATA_W-1:0] rdata_c;

   // Timer writes are honoured regardless of exception/eret
   assign count_we   = bus.mtc0 && (bus.rd == CP0_COUNT);
   assign compare_we = bus.mtc0 && (bus.rd == CP0_COMPARE);

   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (count_we),
      .compare_we (compare_we),
      .wdata      (bus.wdata),
      .count      (count),
      .compare    (compare),
      .match_c    (match_c)
   );

   // Next-state: exception > eret > mtc0 for Status/Cause/EPC
   always_comb begin
      status_d = status_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      if (bus.exception) begin
         epc_d = bus.pc;
         cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = bus.cause;
         status_d = status_q << EXC_SHIFT;
      end else if (bus.eret) begin
         status_d = status_q >> EXC_SHIFT;
      end else if (bus.mtc0) begin
         case (bus.rd)
            CP0_STATUS: status_d = bus.wdata;
            CP0_CAUSE:  cause_d[CAUSE_SW_MSB:CAUSE_SW_LSB] = bus.wdata[CAUSE_SW_MSB:CAUSE_SW_LSB];
            CP0_EPC:    epc_d = bus.wdata;
            default:    ;
         endcase
      end
      // IP7 is sticky; a Compare write clears it even against a same-cycle match
      if (compare_we)   cause_d[CAUSE_IP7] = 1'b0;
      else if (match_c) cause_d[CAUSE_IP7] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status_q <= STATUS_RESET;
         cause_q  <= '0;
         epc_q    <= '0;
      end else begin
         status_q <= status_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
      end
   end

   // Zero-latency read mux; returns pre-write values during a same-cycle mtc0
   always_comb begin
      rdata_c = '0;
      if (bus.mfc0) begin
         case (bus.rd)
            CP0_COUNT:   rdata_c = count;
            CP0_COMPARE: rdata_c = compare;
            CP0_STATUS:  rdata_c = status_q;
            CP0_CAUSE:   rdata_c = cause_q;
            CP0_EPC:     rdata_c = epc_q;
            default:     rdata_c = '0;
         endcase
      end
   end

   assign bus.rdata     = rdata_c;
   assign bus.status    = status_q;
   assign bus.exc_addr  = bus.eret ? epc_q : EXC_VECTOR;
   assign bus.timer_irq = status_q[STATUS_IE] & status_q[STATUS_IM7] & cause_q[CAUSE_IP7];

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block directly downstream of the multi-cycle CPU core; consumes its cpu_cp0_* control/data outputs and returns cp0_cpu_rdata, cp0_cpu_status and cp0_cpu_exc_addr.
- Holds the Status, Cause, EPC, Count and Compare registers, performs exception entry and return bookkeeping, and raises a Count/Compare timer interrupt request for the controller.

Parameters:
- EXC_VECTOR, 32'h0040_0004, exception handler entry address driven on exc_addr when eret is low.
- STATUS_RESET, 32'h0000_0001, Status value loaded on reset.
- EXC_SHIFT, 5, bit shift applied to Status on exception entry (left) and eret (right).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset, driven from cpu_cp0_rst.
- mfc0  in  1  read strobe; rdata is valid combinationally while high.
- mtc0  in  1  write strobe; writes wdata to register rd at the clock edge.
- pc  in  32  PC of the excepting instruction, captured into EPC.
- rd  in  5  CP0 register index: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
- wdata  in  32  mtc0 write data.
- exception  in  1  exception entry strobe, one cycle wide.
- eret  in  1  exception return strobe, one cycle wide.
- cause  in  5  ExcCode for exception: 8 syscall, 9 break, 13 teq.
- rdata  out  32  register read data; 0 when mfc0 is low or rd is unimplemented.
- status  out  32  current Status register.
- exc_addr  out  32  combinational: EPC when eret is high, otherwise EXC_VECTOR.
- timer_irq  out  1  Status[0] & Status[15] & Cause[15].

Behaviour:
- Reset (synchronous, highest priority): Status=STATUS_RESET; Cause, EPC, Count and Compare = 0. All outputs follow at the same edge: rdata=0, timer_irq=0, exc_addr=EXC_VECTOR.
- Reads are combinational with zero latency. An mfc0 in the same cycle as an mtc0 to the same register returns the pre-write value.
- Exception edge:
  - EPC <= pc.
  - Cause[6:2] <= cause; other Cause bits are retained.
  - Status <= Status << EXC_SHIFT, zero-filled; this disables interrupts.
- Eret edge: Status <= Status >> EXC_SHIFT, zero-filled. EPC is unchanged.
- Priority per cycle: reset > exception > eret > mtc0. A lower-priority Status/Cause/EPC write in the same cycle is dropped.
  - Exception with eret: only the exception takes effect.
  - Exception with mtc0 to Status, Cause or EPC: the mtc0 is dropped.
  - mtc0 to Count or Compare is still honoured alongside an exception.
- mtc0 write masks:
  - Status: all 32 bits.
  - EPC: all 32 bits.
  - Cause: bits 9:8 only (software interrupt bits); other bits keep their value.
  - Count: loads wdata; no increment that cycle.
  - Compare: loads wdata and clears Cause[15] at the same edge.
  - Any other rd: ignored.
- Timer:
  - Count increments by 1 every cycle not overwritten by mtc0; wraps 32'hFFFF_FFFF to 0 with no flag.
  - When the next Count equals Compare and Compare is nonzero, Cause[15] is set at that edge.
  - Cause[15] is sticky until cleared by a Compare write or reset.
  - If a Compare write and a match occur in the same cycle, the clear wins.
- Reset asserted mid-sequence (e.g. in the exception cycle) discards the pending update entirely.

Decomposition:
- Shared package cp0_pkg holds:
  - register index constants CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14;
  - ExcCode constants EXC_SYSCALL=8, EXC_BREAK=9, EXC_TEQ=13;
  - the Cause IP7 bit index 15.
- One sub-module, cp0_timer:
  - holds Count and Compare;
  - takes the write strobes;
  - produces the match pulse.
- The Cause IP7 sticky bit stays in cp0_unit.

Test Plan:
- Reset, then mfc0 rd=12 -> rdata=32'h0000_0001; rd=14 -> 0; rd=5 -> 0; exc_addr=32'h0040_0004.
- mtc0 rd=12 wdata=32'h0000_8001; next cycle exception=1, cause=8, pc=32'h0040_0100 -> status=32'h0010_0020, EPC=32'h0040_0100, Cause[6:2]=8. Then eret=1 -> exc_addr=32'h0040_0100 that cycle, status=32'h0000_8001 next.
- exception and eret together, cause=9 -> status shifted left only, Cause[6:2]=9; the eret has no effect.
- mtc0 rd=11 wdata=10, mtc0 rd=9 wdata=0 -> Cause[15] sets when Count reaches 10 and timer_irq=1 with Status=32'h0000_8001. mtc0 rd=11 wdata=50 -> timer_irq=0 next cycle.
- mtc0 rd=9 wdata=32'hFFFF_FFFF -> Count reads 0 on the following cycle. Also, mtc0 rd=13 wdata=32'hFFFF_FFFF -> Cause reads 32'h0000_0300.
- exception with mtc0 rd=14 wdata=32'h1234 -> EPC=pc (the mtc0 is dropped). Reset asserted in the same cycle as an exception -> all registers hold their reset values.
